ctrl_event_queue: RTL

CTRL_EVENT_QUEUE -- requirements
Module: ctrl_event_queue

---
 rtl/ctrl_evt_pkg.sv | 20 ++
 rtl/evt_fifo.sv | 51 +++++
 rtl/ctrl_event_queue.sv | 89 ++++++++
 3 files changed

// File: rtl/ctrl_evt_pkg.sv
// rtl/ctrl_evt_pkg.sv - shared widths and event record for the controller event queue
package ctrl_evt_pkg;

  localparam int MASK_W = 13;
  localparam int EVT_W  = 2 * MASK_W;

  typedef struct packed {
    logic [MASK_W-1:0] pressed;
    logic [MASK_W-1:0] released;
  } evt_t;

  function automatic evt_t make_evt(input logic [MASK_W-1:0] prev,
                                    input logic [MASK_W-1:0] next);
    evt_t e;
    e.pressed  = next & ~prev;
    e.released = prev & ~next;
    return e;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// rtl/evt_fifo.sv - first-word-fall-through FIFO; a push onto a full FIFO is dropped unless a pop frees a slot
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 26,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [CW-1:0]    count,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign valid   = (cnt != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = valid ? mem[rd_ptr] : '0;
  assign count = cnt;

endmodule

// File: rtl/ctrl_event_queue.sv
// rtl/ctrl_event_queue.sv - turns strobed button masks into press/release events queued in a FIFO
// Optional frame debounce is enabled by defining CTRL_EVT_DEBOUNCE_EN.
module ctrl_event_queue
  import ctrl_evt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MASK_W-1:0]           bit_mask,
  input  logic                        bit_mask_ready,
  input  logic                        rd_en,
  input  logic                        clr_overflow,
  output logic [MASK_W-1:0]           cur_mask,
  output logic                        evt_valid,
  output logic [MASK_W-1:0]           evt_pressed,
  output logic [MASK_W-1:0]           evt_released,
  output logic [$clog2(FIFO_DEPTH):0] evt_count,
  output logic                        overflow
);

  logic [MASK_W-1:0] cur_q;
  logic              ovf_q;
  logic              accept;
  logic              change;
  logic              drop;
  logic              fifo_full;
  evt_t              new_evt;
  evt_t              head;
  logic [EVT_W-1:0]  head_raw;

`ifdef CTRL_EVT_DEBOUNCE_EN
  // A frame counts only once it has been seen on two consecutive strobes.
  logic [MASK_W-1:0] cand;
  logic              cand_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand       <= '0;
      cand_valid <= 1'b0;
    end else if (bit_mask_ready) begin
      cand       <= bit_mask;
      cand_valid <= 1'b1;
    end
  end

  assign accept = bit_mask_ready && cand_valid && (bit_mask == cand);
`else
  assign accept = bit_mask_ready;
`endif

  assign change  = accept && (bit_mask != cur_q);
  assign new_evt = make_evt(cur_q, bit_mask);
  assign drop    = change && fifo_full && !(rd_en && evt_valid);

  evt_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (change),
    .pop   (rd_en),
    .wdata (new_evt),
    .rdata (head_raw),
    .valid (evt_valid),
    .count (evt_count),
    .full  (fifo_full)
  );

  // The button state tracks the input even when its event is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (change) cur_q <= bit_mask;
      if (drop)              ovf_q <= 1'b1;
      else if (clr_overflow) ovf_q <= 1'b0;
    end
  end

  assign head         = head_raw;
  assign cur_mask     = cur_q;
  assign evt_pressed  = head.pressed;
  assign evt_released = head.released;
  assign overflow     = ovf_q;

endmodule
